// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction memory port, redirect input and decode handshake.
// master = fetch_unit, slave = memory/decode side.
interface fetch_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output mem_addr, inst_valid, inst, inst_pc,
    input  mem_inst, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_addr, inst_valid, inst, inst_pc,
    output mem_inst, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, one-cycle memory latency tracking, return FIFO.
// Define FETCH_BYPASS_EN to forward returning data straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t          count_q, count_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic fifo_empty, capture, bypass, pop, fifo_pop, push, issue;
  cnt_t credit;

  assign bus.mem_addr = {2'b00, pc_q[31:2]};
  assign fifo_empty   = (count_q == '0);
  assign capture      = inflight_q && !bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = capture && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.inst_pc    = '0;
    if (!fifo_empty) begin
      bus.inst_valid = 1'b1;
      bus.inst       = fifo_inst_q[rd_ptr_q];
      bus.inst_pc    = fifo_pc_q[rd_ptr_q];
    end else if (bypass) begin
      bus.inst_valid = 1'b1;
      bus.inst       = bus.mem_inst;
      bus.inst_pc    = inflight_pc_q;
    end
  end

  assign pop      = bus.inst_valid && bus.inst_ready;
  assign fifo_pop = pop && !fifo_empty;
  // A bypassed word that decode takes this cycle never needs a FIFO slot.
  assign push     = capture && !(bypass && pop);
  // Slots already promised: buffered words plus the one still in memory, minus what leaves now.
  assign credit   = count_q + cnt_t'(inflight_q) - cnt_t'(pop);
  assign issue    = !bus.redirect_valid && (credit < cnt_t'(DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
      if (push)     wr_ptr_d = wr_ptr_q + AW'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= bus.mem_inst;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifndef SYNTHESIS
  push_not_full_a: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == cnt_t'(DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {inst, pc}, a negedge monitor checks.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  logic [63:0] sb [$];

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x11, 0x22, 0x33 at words 0..2, otherwise a tag derived from the index.
  function automatic logic [31:0] memval(input logic [31:0] idx);
    if (idx < 32'd3) return (idx + 32'd1) * 32'h11;
    return 32'hC000_0000 ^ idx;
  endfunction

  always @(posedge clk) bus.mem_inst <= memval(bus.mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back({memval(pc >> 2), pc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset(input logic rdy);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    step();
    step();
    rst_n          = 1'b1;
    bus.inst_ready = rdy;
    cyc            = 0;
  endtask

  task automatic basic_seq();
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    chk("c0_mem_addr", bus.mem_addr, 32'h0);
    chk("c0_valid", {31'b0, bus.inst_valid}, 32'd0);
    goto(LAT - 1);
    chk("pre_lat_valid", {31'b0, bus.inst_valid}, 32'd0);
    goto(LAT);
    chk("lat_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("lat_pc", bus.inst_pc, 32'h0);
    chk("lat_inst", bus.inst, 32'h11);
    goto(LAT + 3);
    bus.inst_ready = 1'b0;
    goto(LAT + 6);
    chk("basic_sb_empty", sb.size(), 32'd0);
  endtask

  // Monitor: checks transfers against the scoreboard, idle zeros, and hold stability.
  logic        hold_v;
  logic [31:0] hold_inst, hold_pc;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_inst", bus.inst, hold_inst);
        chk("hold_pc", bus.inst_pc, hold_pc);
      end
      if (!bus.inst_valid) begin
        chk("idle_inst", bus.inst, 32'h0);
        chk("idle_pc", bus.inst_pc, 32'h0);
      end else if (bus.inst_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got pc %h inst %h want none (cycle %0d)",
                   bus.inst_pc, bus.inst, cyc);
        end else begin
          e = sb.pop_front();
          chk("xfer_inst", bus.inst, e[63:32]);
          chk("xfer_pc", bus.inst_pc, e[31:0]);
        end
      end
      hold_v    = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
      hold_inst = bus.inst;
      hold_pc   = bus.inst_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    total              = 0;
    bad                = 0;
    cyc                = 0;
    hold_v             = 1'b0;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    #12;
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);

    // Straight-line fetch with decode always ready.
    do_reset(1'b1);
    basic_seq();

    // Backpressure: buffering stops at DEPTH, head word held steady.
    do_reset(1'b0);
    goto(3);
    chk("bp_inst_c3", bus.inst, 32'h11);
    goto(10);
    chk("bp_mem_addr", bus.mem_addr, 32'h2);
    chk("bp_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("bp_inst", bus.inst, 32'h11);
    chk("bp_pc", bus.inst_pc, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    goto(11);
    bus.inst_ready = 1'b1;
    goto(14);
    bus.inst_ready = 1'b0;
    goto(16);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Redirect to 0x43 in cycle 5 while streaming.
    do_reset(1'b1);
    for (int k = 0; k < 6 - LAT; k++) expect_pc(32'(4 * k));
    goto(5);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_mem_addr", bus.mem_addr, 32'h10);
    for (int k = 6; k <= 5 + LAT; k++) begin
      goto(k);
      chk("rd_gap_valid", {31'b0, bus.inst_valid}, 32'd0);
    end
    expect_pc(32'h40);
    expect_pc(32'h44);
    goto(6 + LAT);
    chk("rd_first_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("rd_first_pc", bus.inst_pc, 32'h40);
    goto(8 + LAT);
    bus.inst_ready = 1'b0;
    goto(11 + LAT);
    chk("rd_sb_empty", sb.size(), 32'd0);

    // Pop and redirect together with the FIFO full.
    do_reset(1'b0);
    goto(6);
    expect_pc(32'h0);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    chk("pr_empty_valid", {31'b0, bus.inst_valid}, 32'd0);
    expect_pc(32'h100);
    expect_pc(32'h104);
    goto(9 + LAT);
    bus.inst_ready = 1'b0;
    goto(12 + LAT);
    chk("pr_sb_empty", sb.size(), 32'd0);

    // Redirect to the top of the address space and wrap.
    do_reset(1'b0);
    goto(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("wr_mem_addr", bus.mem_addr, 32'h3FFF_FFFF);
    bus.inst_ready = 1'b1;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    goto(4 + LAT);
    chk("wr_top_pc", bus.inst_pc, 32'hFFFF_FFFC);
    goto(6 + LAT);
    bus.inst_ready = 1'b0;
    goto(9 + LAT);
    chk("wr_sb_empty", sb.size(), 32'd0);

    // Reset mid-stream with a fetch in flight, then a clean restart.
    do_reset(1'b1);
    for (int k = 0; k < 5 - LAT; k++) expect_pc(32'(4 * k));
    goto(5);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("mr_inst", bus.inst, 32'h0);
    chk("mr_pc", bus.inst_pc, 32'h0);
    chk("mr_mem_addr", bus.mem_addr, 32'h0);
    chk("mr_sb_empty", sb.size(), 32'd0);
    do_reset(1'b1);
    basic_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the hotate core. Drives word addresses into the synchronous instruction memory, tracks its one-cycle read latency, buffers returned words in a small FIFO, and hands `{inst, inst_pc}` to decode over a valid/ready handshake. Branch/jump redirects squash in-flight and buffered fetches and restart the PC.

## Interface
- `RESET_PC`, 32'h0000_0000, byte PC loaded at reset; bits [1:0] must be 0
- `DEPTH`, 2, FIFO entries; power of two, ≥ 2

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_addr`  out  32  word index to instruction memory = `{2'b00, pc[31:2]}`, combinational from `pc`
- `mem_inst`  in  32  memory read data; valid in cycle N+1 for the `mem_addr` sampled at the end of cycle N
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new byte PC; bits [1:0] ignored, treated as 0
- `inst_valid`  out  1  `inst`/`inst_pc` hold a fetched instruction
- `inst_ready`  in  1  decode accepts; transfer when `inst_valid && inst_ready`
- `inst`  out  32  instruction word; 0 when `inst_valid`=0
- `inst_pc`  out  32  byte PC of `inst`; 0 when `inst_valid`=0

## Operation
- State: `pc` (32), `inflight` (1), `inflight_pc` (32), FIFO of `DEPTH` `{inst, pc}` entries with count 0..DEPTH.
- Reset (`rst`=0, async): `pc`=RESET_PC, `inflight`=0, FIFO empty; `inst_valid`=0, `inst`=0, `inst_pc`=0, `mem_addr`=RESET_PC>>2.
- `pop` = `inst_valid && inst_ready`.
- Issue: `issue` = `!redirect_valid && (count + inflight − pop) < DEPTH`. On issue: `inflight`←1, `inflight_pc`←`pc`, `pc`←`pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). Otherwise `inflight`←0, `pc` holds.
- Capture: if `inflight && !redirect_valid`, push `{mem_inst, inflight_pc}` into FIFO. Credit rule guarantees no push onto a full FIFO; push-when-full is a design error (assertion).
- Pop and push in the same cycle: both occur, count unchanged.
- Redirect (`redirect_valid`=1): FIFO flushed, `inflight`←0, no issue, no capture, `pc`←`{redirect_pc[31:2],2'b00}`. Data returning in the redirect cycle is discarded. A `pop` in the redirect cycle is a completed transfer; decode owns discarding it.
- Redirect during reset has no effect. Redirect on consecutive cycles: last one wins.
- FIFO ordering strictly in PC issue order; no instruction duplicated or dropped absent a redirect.

## Timing
- Fetch latency (reset release or redirect to `inst_valid`): issue in cycle C, data at C+1, `inst_valid` at C+2.
- After reset release at cycle 0: `mem_addr`=RESET_PC>>2 in cycle 0, `inst_valid`=1 with `inst_pc`=RESET_PC in cycle 2.
- Redirect in cycle R: new `mem_addr` in R+1; `inst_valid`=0 in R+1 and R+2; first new instruction valid in R+3.
- Steady state with `inst_ready`=1: one instruction per cycle, sequential PCs.
- With `inst_ready`=0: issue stops once count + inflight = DEPTH; `inst`/`inst_pc` stable while `inst_valid`=1 and not popped.
- Reset asserted mid-operation: all state cleared immediately; in-flight data ignored.

## Configuration
- `FETCH_BYPASS_EN` defined: when FIFO is empty and capture occurs, `inst_valid`=1 combinationally in the capture cycle with `inst`=`mem_inst`, `inst_pc`=`inflight_pc`; if popped, not written into the FIFO. Latency becomes 1 (post-reset valid in cycle 1; post-redirect in R+2).
- Not defined: all instructions pass through the FIFO; latencies as in Timing. `inst` and `inst_pc` are purely registered.

## Test plan
- Reset release, memory words 0x11,0x22,0x33 at 0,4,8, `inst_ready`=1 -> `inst_valid` from cycle 2, outputs (0x11,0),(0x22,4),(0x33,8) on consecutive cycles.
- `inst_ready`=0 for 10 cycles after reset -> at most 2 words buffered, `mem_addr` stops at 2, `inst`=0x11 stable; release -> 0x11,0x22,0x33 with no gap or duplication.
- `redirect_valid` with `redirect_pc`=0x43 in cycle 5 -> `inst_valid`=0 cycles 6–7, cycle 8 `inst_pc`=0x40, no pre-redirect word appears after cycle 5.
- Pop and redirect in same cycle with FIFO full -> popped word transferred once, FIFO empty next cycle, restart at new PC.
- Redirect to 0xFFFF_FFFC -> `inst_pc` 0xFFFF_FFFC then 0x0000_0000.
- `rst` asserted mid-stream with words in flight -> outputs 0 immediately, after release sequence restarts at RESET_PC exactly as first test (with `FETCH_BYPASS_EN`: valid from cycle 1).
